// File: rtl/four_bank_mem_if.sv
// Request/response bundle between the cache controller's memory port and the
// four-bank memory responder.
interface four_bank_mem_if;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic        rd_valid;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  modport master (
    output addr, data_in, wr, rd,
    input  data_out, rd_valid, stall, busy, err
  );

  modport slave (
    input  addr, data_in, wr, rd,
    output data_out, rd_valid, stall, busy, err
  );
endinterface

// File: rtl/four_bank_mem.sv
// Four interleaved 16-bit memory banks, each busy for four cycles per access,
// with a fixed two-cycle read latency and no request queuing.
module four_bank_mem #(
  parameter int unsigned BANK_AW = 6
) (
  input logic          clk,
  input logic          rst,
  four_bank_mem_if.slave bus
);

  localparam int unsigned NBANK = 4;
  localparam int unsigned DEPTH = 2 ** BANK_AW;
  localparam int unsigned DW    = 16;

  logic [DW-1:0]      mem [NBANK][DEPTH];
  logic [1:0]         cnt [NBANK];
  logic [NBANK-1:0]   busy_c;
  logic [1:0]         bank_c;
  logic [BANK_AW-1:0] row_c;
  logic               req_c;
  logic               acc_c;
  logic               s1_valid;
  logic [DW-1:0]      s1_data;
  logic               addr_unused_c;

  // Request decode: a request is valid only when exactly one of rd/wr is high.
  always_comb begin
    bank_c = bus.addr[2:1];
    row_c  = bus.addr[BANK_AW+2:3];
    req_c  = bus.rd ^ bus.wr;
    for (int b = 0; b < int'(NBANK); b++) begin
      busy_c[b] = (cnt[b] != 2'd0);
    end
    acc_c  = req_c & ~busy_c[bank_c];
  end

  assign addr_unused_c = ^{bus.addr[15:BANK_AW+3], bus.addr[0]};

  assign bus.busy  = busy_c;
  assign bus.stall = req_c & busy_c[bank_c];
  assign bus.err   = bus.rd & bus.wr;

  // Per-bank occupancy counters: 3 on acceptance, then count down to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < int'(NBANK); b++) begin
        cnt[b] <= 2'd0;
      end
    end else begin
      for (int b = 0; b < int'(NBANK); b++) begin
        if (acc_c && (bank_c == 2'(b))) begin
          cnt[b] <= 2'd3;
        end else if (cnt[b] != 2'd0) begin
          cnt[b] <= cnt[b] - 2'd1;
        end
      end
    end
  end

  // Storage array is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (acc_c && bus.wr) begin
      mem[bank_c][row_c] <= bus.data_in;
    end
  end

  // Two-stage read pipeline; data_out is forced to zero when not valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_data      <= '0;
      bus.rd_valid <= 1'b0;
      bus.data_out <= '0;
    end else begin
      s1_valid     <= acc_c & bus.rd;
      s1_data      <= (acc_c && bus.rd) ? mem[bank_c][row_c] : '0;
      bus.rd_valid <= s1_valid;
      bus.data_out <= s1_valid ? s1_data : '0;
    end
  end

endmodule

// File: tb/tb_four_bank_mem.sv
// Self-checking bench for four_bank_mem: per-cycle vector table for stall/err/busy
// plus a timed scoreboard of expected read data.
module tb_four_bank_mem;

  logic clk;
  logic rst;
  four_bank_mem_if bus_if ();

  four_bank_mem #(.BANK_AW(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic        stall;
    logic        err;
    logic [3:0]  busy;
    logic        push;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic row(input logic rd, input logic wr, input logic [15:0] addr,
                     input logic [15:0] din, input logic stall, input logic err,
                     input logic [3:0] busy, input logic push, input logic [15:0] exp);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.din = din;
    v.stall = stall; v.err = err; v.busy = busy; v.push = push; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic idle(input logic [3:0] busy);
    row(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, busy, 1'b0, 16'h0000);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] din);
    bus_if.rd = rd; bus_if.wr = wr; bus_if.addr = addr; bus_if.data_in = din;
  endtask

  // Read-data monitor: every rd_valid must match the next scheduled read exactly.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus_if.rd_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rd_valid", 16'(bus_if.rd_valid), 16'h0000);
        end else if (sb[0].cyc > cyc) begin
          chk("early_rd_valid_cycle", 16'(cyc), 16'(sb[0].cyc));
        end else begin
          chk("rd_cycle", 16'(cyc), 16'(sb[0].cyc));
          chk("rd_data", bus_if.data_out, sb[0].data);
          void'(sb.pop_front());
        end
      end else begin
        chk("idle_data_out", bus_if.data_out, 16'h0000);
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          chk("missed_rd_valid", 16'(bus_if.rd_valid), 16'h0001);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    @(negedge clk);
    chk("reset_rd_valid", 16'(bus_if.rd_valid), 16'h0000);
    chk("reset_data_out", bus_if.data_out, 16'h0000);
    chk("reset_busy", 16'(bus_if.busy), 16'h0000);
    chk("reset_stall", 16'(bus_if.stall), 16'h0000);
    chk("reset_err", 16'(bus_if.err), 16'h0000);

    // Burst write to all four banks, wait, then burst read back.
    row(0, 1, 16'h1230, 16'hA000, 0, 0, 4'b0000, 0, 16'h0);
    row(0, 1, 16'h1232, 16'hA001, 0, 0, 4'b0001, 0, 16'h0);
    row(0, 1, 16'h1234, 16'hA002, 0, 0, 4'b0011, 0, 16'h0);
    row(0, 1, 16'h1236, 16'hA003, 0, 0, 4'b0111, 0, 16'h0);
    idle(4'b1110); idle(4'b1100); idle(4'b1000); idle(4'b0000); idle(4'b0000);
    row(1, 0, 16'h1230, 16'h0000, 0, 0, 4'b0000, 1, 16'hA000);
    row(1, 0, 16'h1232, 16'h0000, 0, 0, 4'b0001, 1, 16'hA001);
    row(1, 0, 16'h1234, 16'h0000, 0, 0, 4'b0011, 1, 16'hA002);
    row(1, 0, 16'h1236, 16'h0000, 0, 0, 4'b0111, 1, 16'hA003);
    idle(4'b1110); idle(4'b1100); idle(4'b1000); idle(4'b0000);
    // Bank conflict: write bank 0, then read the same bank until it frees.
    row(0, 1, 16'h0008, 16'h5A5A, 0, 0, 4'b0000, 0, 16'h0);
    row(1, 0, 16'h0008, 16'h0000, 1, 0, 4'b0001, 0, 16'h0);
    row(1, 0, 16'h0008, 16'h0000, 1, 0, 4'b0001, 0, 16'h0);
    row(1, 0, 16'h0008, 16'h0000, 1, 0, 4'b0001, 0, 16'h0);
    row(1, 0, 16'h0008, 16'h0000, 0, 0, 4'b0000, 1, 16'h5A5A);
    idle(4'b0001); idle(4'b0001); idle(4'b0001); idle(4'b0000);
    // Error: rd and wr together must not touch the array or bank state.
    row(0, 1, 16'h0002, 16'h1111, 0, 0, 4'b0000, 0, 16'h0);
    idle(4'b0010); idle(4'b0010); idle(4'b0010); idle(4'b0000);
    row(1, 1, 16'h0002, 16'hFFFF, 0, 1, 4'b0000, 0, 16'h0);
    row(1, 0, 16'h0002, 16'h0000, 0, 0, 4'b0000, 1, 16'h1111);
    idle(4'b0010); idle(4'b0010); idle(4'b0010);
    // Independence: write bank 1 then read bank 2 with no stall.
    row(0, 1, 16'h0012, 16'h2222, 0, 0, 4'b0000, 0, 16'h0);
    row(1, 0, 16'h1234, 16'h0000, 0, 0, 4'b0010, 1, 16'hA002);
    idle(4'b0110); idle(4'b0110); idle(4'b0100); idle(4'b0000);
    // Counter expiry: same-bank request accepted exactly four cycles later.
    row(1, 0, 16'h1236, 16'h0000, 0, 0, 4'b0000, 1, 16'hA003);
    idle(4'b1000); idle(4'b1000); idle(4'b1000);
    row(1, 0, 16'h1236, 16'h0000, 0, 0, 4'b0000, 1, 16'hA003);
    idle(4'b1000); idle(4'b1000); idle(4'b1000); idle(4'b0000);
    row(1, 0, 16'h0012, 16'h0000, 0, 0, 4'b0000, 1, 16'h2222);
    idle(4'b0010); idle(4'b0010); idle(4'b0010); idle(4'b0000);

    foreach (tbl[i]) begin
      @(posedge clk);
      #1 drive(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].din);
      if (tbl[i].push) sb.push_back('{cyc + 2, tbl[i].exp});
      @(negedge clk);
      chk($sformatf("stall[%0d]", i), 16'(bus_if.stall), 16'(tbl[i].stall));
      chk($sformatf("err[%0d]", i), 16'(bus_if.err), 16'(tbl[i].err));
      chk($sformatf("busy[%0d]", i), 16'(bus_if.busy), 16'(tbl[i].busy));
    end

    // Reset mid-read: the second in-flight read must be dropped.
    @(posedge clk); #1 drive(1'b1, 1'b0, 16'h1230, 16'h0000);
    @(posedge clk); #1 drive(1'b1, 1'b0, 16'h1232, 16'h0000);
    @(posedge clk); #1 drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("pre_reset_rd_valid", 16'(bus_if.rd_valid), 16'h0001);
    chk("pre_reset_data_out", bus_if.data_out, 16'hA000);
    #1 rst = 1'b1;
    #1;
    chk("midrst_data_out", bus_if.data_out, 16'h0000);
    chk("midrst_rd_valid", 16'(bus_if.rd_valid), 16'h0000);
    chk("midrst_busy", 16'(bus_if.busy), 16'h0000);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(negedge clk);

    // Array contents survive reset.
    @(posedge clk); #1 drive(1'b1, 1'b0, 16'h1230, 16'h0000);
    sb.push_back('{cyc + 2, 16'hA000});
    @(negedge clk);
    chk("post_reset_stall", 16'(bus_if.stall), 16'h0000);
    @(posedge clk); #1 drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (5) @(negedge clk);
    chk("scoreboard_pending", 16'(sb.size()), 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
